// File: rtl/rle_run_counter_if.sv
// Stream interface for the run-length encoder: an uncompressed word input and
// a (data, count) beat output, each with a valid/ready handshake.
interface rle_run_counter_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] data;
    logic [7:0]  count;
    logic        selector;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, data, count, selector, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, data, count, selector, out_valid
    );
endinterface

// File: rtl/rle_run_counter.sv
// Run-length encoder: collapses repeated 32-bit words into (word, count) pairs.
// Each pair leaves as two registered beats, data first (selector=0), then count.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | no open run, waiting for a first word
// ST_RUN    | run open; run_word/run_cnt hold the current run
// ST_EMIT_D | data beat presented, waiting for out_ready
// ST_EMIT_C | count beat presented, waiting for out_ready
module rle_run_counter #(
    parameter int MAX_RUN = 255
) (
    input logic          clk,
    input logic          rst_n,
    rle_run_counter_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_EMIT_D = 2'd2;
    localparam logic [1:0] ST_EMIT_C = 2'd3;

    localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

    logic [1:0]  state;
    logic [31:0] run_word;
    logic [7:0]  run_cnt;
    logic [31:0] pend_word;
    logic        pend_valid;
    logic        pend_last;

    logic [31:0] data_q;
    logic [7:0]  count_q;
    logic        sel_q;
    logic        valid_q;

    logic        accept_ok;
    logic        in_fire;
    logic        out_fire;
    logic        same_word;
    logic [7:0]  cnt_inc;

    assign accept_ok = (state == ST_IDLE) || (state == ST_RUN);
    assign in_fire   = bus.in_valid & accept_ok;
    assign out_fire  = valid_q & bus.out_ready;
    assign same_word = (bus.in_data == run_word);
    assign cnt_inc   = run_cnt + 8'd1;

    assign bus.in_ready  = accept_ok;
    assign bus.data      = data_q;
    assign bus.count     = count_q;
    assign bus.selector  = sel_q;
    assign bus.out_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            run_word   <= '0;
            run_cnt    <= '0;
            pend_word  <= '0;
            pend_valid <= 1'b0;
            pend_last  <= 1'b0;
            data_q     <= '0;
            count_q    <= '0;
            sel_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        run_word <= bus.in_data;
                        run_cnt  <= 8'd1;
                        if (bus.in_last || (MAX_CNT == 8'd1)) begin
                            state   <= ST_EMIT_D;
                            data_q  <= bus.in_data;
                            count_q <= 8'd1;
                            sel_q   <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (in_fire) begin
                        if (same_word) begin
                            run_cnt <= cnt_inc;
                            if ((cnt_inc == MAX_CNT) || bus.in_last) begin
                                state   <= ST_EMIT_D;
                                data_q  <= run_word;
                                count_q <= cnt_inc;
                                sel_q   <= 1'b0;
                                valid_q <= 1'b1;
                            end
                        end else begin
                            // New word closes the old run; it waits in pend_* until the pair is out.
                            pend_word  <= bus.in_data;
                            pend_valid <= 1'b1;
                            pend_last  <= bus.in_last;
                            state      <= ST_EMIT_D;
                            data_q     <= run_word;
                            count_q    <= run_cnt;
                            sel_q      <= 1'b0;
                            valid_q    <= 1'b1;
                        end
                    end
                end

                ST_EMIT_D: begin
                    if (out_fire) begin
                        state <= ST_EMIT_C;
                        sel_q <= 1'b1;
                    end
                end

                ST_EMIT_C: begin
                    if (out_fire) begin
                        sel_q <= 1'b0;
                        if (pend_valid) begin
                            run_word   <= pend_word;
                            run_cnt    <= 8'd1;
                            pend_valid <= 1'b0;
                            pend_last  <= 1'b0;
                            if (pend_last || (MAX_CNT == 8'd1)) begin
                                state   <= ST_EMIT_D;
                                data_q  <= pend_word;
                                count_q <= 8'd1;
                                valid_q <= 1'b1;
                            end else begin
                                state   <= ST_RUN;
                                valid_q <= 1'b0;
                            end
                        end else begin
                            state   <= ST_IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    sel_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rle_run_counter.sv
// Directed bench for rle_run_counter: hand-computed beat sequences, stalls,
// mid-emit reset and a decode-and-compare scoreboard for a mixed stream.
module tb_rle_run_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rle_run_counter_if bus();

    rle_run_counter #(.MAX_RUN(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    logic        beat_sel[$];
    logic [31:0] beat_data[$];
    logic [7:0]  beat_cnt[$];

    // Beats are logged mid-cycle; the handshake itself lands on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            beat_sel.push_back(bus.selector);
            beat_data.push_back(bus.data);
            beat_cnt.push_back(bus.count);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        beat_sel.delete();
        beat_data.delete();
        beat_cnt.delete();
    endtask

    task automatic send(input logic [31:0] w, input logic last);
        int n;
        n = 0;
        bus.in_data  = w;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.in_ready) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k;
        k = 0;
        while (beat_sel.size() < n && k < 1000) begin
            tick();
            k++;
        end
        chk(tag, 32'(beat_sel.size()), 32'(n));
    endtask

    task automatic chk_pair(input string tag, input int idx, input logic [31:0] w, input logic [7:0] c);
        if (beat_sel.size() >= idx + 2) begin
            chk({tag, "_dsel"},  32'(beat_sel[idx]),      32'd0);
            chk({tag, "_data"},  beat_data[idx],          w);
            chk({tag, "_csel"},  32'(beat_sel[idx + 1]),  32'd1);
            chk({tag, "_cdata"}, beat_data[idx + 1],      w);
            chk({tag, "_count"}, 32'(beat_cnt[idx + 1]),  32'(c));
        end else begin
            chk({tag, "_present"}, 32'(beat_sel.size()), 32'(idx + 2));
        end
    endtask

    logic [31:0] stream[7];
    logic [31:0] decoded[$];

    initial begin
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",      bus.data,            32'h0);
        chk("rst_count",     32'(bus.count),      32'd0);
        chk("rst_selector",  32'(bus.selector),   32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready",  32'(bus.in_ready),   32'd1);

        // A0 x3 then FF with last
        bus.out_ready = 1'b1;
        clear_beats();
        send(32'hA0A0A0A0, 1'b0);
        send(32'hA0A0A0A0, 1'b0);
        send(32'hA0A0A0A0, 1'b0);
        send(32'hFFFFFFFF, 1'b1);
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_data",      bus.data,            32'hA0A0A0A0);
        chk("lat_count",     32'(bus.count),      32'd3);
        chk("lat_in_ready",  32'(bus.in_ready),   32'd0);
        wait_beats("basic_beats", 4);
        chk_pair("basic_p0", 0, 32'hA0A0A0A0, 8'd3);
        chk_pair("basic_p1", 2, 32'hFFFFFFFF, 8'd1);
        repeat (2) tick();
        chk("basic_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("basic_idle_ready", 32'(bus.in_ready),  32'd1);
        chk("basic_idle_sel",   32'(bus.selector),  32'd0);
        chk("basic_hold_data",  bus.data,           32'hFFFFFFFF);
        chk("basic_hold_count", 32'(bus.count),     32'd1);
        chk("basic_n_beats",    32'(beat_sel.size()), 32'd4);

        // 300 zero words: 255 then 45
        clear_beats();
        for (int i = 0; i < 300; i++) send(32'h0, (i == 299));
        wait_beats("long_beats", 4);
        chk_pair("long_p0", 0, 32'h0, 8'd255);
        chk_pair("long_p1", 2, 32'h0, 8'd45);
        repeat (2) tick();
        chk("long_n_beats", 32'(beat_sel.size()), 32'd4);

        // Stall in EMIT_D with a word offered on the input
        bus.out_ready = 1'b0;
        clear_beats();
        send(32'h55555555, 1'b1);
        bus.in_data  = 32'h77777777;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",    32'(bus.out_valid), 32'd1);
            chk("stall_data",     bus.data,           32'h55555555);
            chk("stall_count",    32'(bus.count),     32'd1);
            chk("stall_sel",      32'(bus.selector),  32'd0);
            chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
            tick();
        end
        chk("stall_no_beats", 32'(beat_sel.size()), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_beats("stall_beats", 2);
        chk_pair("stall_p0", 0, 32'h55555555, 8'd1);
        repeat (2) tick();
        chk("stall_idle_valid", 32'(bus.out_valid), 32'd0);

        // Single word with last from IDLE (would show 7777 if it had been swallowed)
        clear_beats();
        send(32'h12345678, 1'b1);
        wait_beats("single_beats", 2);
        chk_pair("single_p0", 0, 32'h12345678, 8'd1);

        // Reset pulsed during EMIT_C
        repeat (2) tick();
        bus.out_ready = 1'b0;
        send(32'hAAAA0001, 1'b0);
        send(32'hAAAA0001, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("emitc_sel",   32'(bus.selector),  32'd1);
        chk("emitc_valid", 32'(bus.out_valid), 32'd1);
        chk("emitc_count", 32'(bus.count),     32'd2);
        clear_beats();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",    32'(bus.out_valid), 32'd0);
        chk("arst_count",    32'(bus.count),     32'd0);
        chk("arst_data",     bus.data,           32'h0);
        chk("arst_sel",      32'(bus.selector),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_in_ready", 32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        send(32'hBBBB0002, 1'b1);
        wait_beats("arst_beats", 2);
        chk_pair("arst_p0", 0, 32'hBBBB0002, 8'd1);
        repeat (2) tick();
        chk("arst_n_beats", 32'(beat_sel.size()), 32'd2);

        // Differing words with in_valid held: decode must reproduce the input
        stream = '{32'h11, 32'h11, 32'h22, 32'h33, 32'h33, 32'h33, 32'h44};
        clear_beats();
        for (int i = 0; i < 7; i++) send(stream[i], (i == 6));
        wait_beats("mix_beats", 8);
        chk_pair("mix_p0", 0, 32'h11, 8'd2);
        chk_pair("mix_p1", 2, 32'h22, 8'd1);
        chk_pair("mix_p2", 4, 32'h33, 8'd3);
        chk_pair("mix_p3", 6, 32'h44, 8'd1);
        decoded.delete();
        for (int i = 0; i + 1 < beat_sel.size(); i += 2) begin
            for (int c = 0; c < int'(beat_cnt[i + 1]); c++) decoded.push_back(beat_data[i]);
        end
        chk("mix_decoded_len", 32'(decoded.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < decoded.size()) chk("mix_decoded_word", decoded[i], stream[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rle_run_counter.md
RLE_RUN_COUNTER -- requirements
Module: rle_run_counter

Interface
REQ-001 Parameter MAX_RUN, default 255, is the maximum run length per emitted pair; the legal range is 1..255.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  is the reset, asynchronous and active-low.
REQ-004 in_data  input  32  is the uncompressed input word.
REQ-005 in_valid  input  1  qualifies in_data.
REQ-006 in_last  input  1  marks the final word of a block; it is qualified by in_valid.
REQ-007 in_ready  output  1  is high when the block accepts a word; a word transfers when in_valid & in_ready.
REQ-008 data  output  32  is the run word, which feeds the selector mux data input.
REQ-009 count  output  8  is the run length, which feeds the selector mux count input.
REQ-010 selector  output  1  selects the beat: 0 = data beat, 1 = count beat.
REQ-011 out_valid  output  1  qualifies data, count and selector.
REQ-012 out_ready  input  1  is the downstream acceptance; a beat transfers when out_valid & out_ready.

Function
REQ-013 The block SHALL implement four states:
- IDLE: no open run.
- RUN: run open; run_word and run_cnt are held.
- EMIT_D: data beat presented.
- EMIT_C: count beat presented.
REQ-014 in_ready SHALL be 1 in IDLE and RUN, and 0 in EMIT_D and EMIT_C.
REQ-015 IDLE plus an accepted word SHALL set run_word = in_data and run_cnt = 1; the next state is RUN, or EMIT_D if in_last=1 or MAX_RUN=1.
REQ-016 RUN plus an accepted word equal to run_word SHALL increment run_cnt; the next state is EMIT_D if the new run_cnt == MAX_RUN or in_last=1, otherwise RUN.
REQ-017 RUN plus an accepted word different from run_word SHALL handle the word as follows:
- latch it into pend_word and set pend_valid=1;
- set pend_last = in_last;
- next state is EMIT_D, closing the old run unchanged.
REQ-018 An EMIT_D cycle SHALL drive out_valid=1, selector=0, data=run_word, count=run_cnt; outputs hold until out_ready, after which the next state is EMIT_C.
REQ-019 An EMIT_C cycle SHALL drive out_valid=1, selector=1, with data and count unchanged from EMIT_D; outputs hold until out_ready.
REQ-020 On EMIT_C handshake with pend_valid=1, the block SHALL set run_word=pend_word, run_cnt=1, pend_valid=0; the next state is EMIT_D if pend_last=1 or MAX_RUN=1, otherwise RUN.
REQ-021 On EMIT_C handshake with pend_valid=0, the next state SHALL be IDLE.
REQ-022 Outputs SHALL be registered; the first data beat is presented one cycle after the closing input handshake.
REQ-023 run_cnt SHALL never exceed MAX_RUN and never wrap; a run longer than MAX_RUN emits multiple pairs, each with count=MAX_RUN except the last.
REQ-024 count SHALL never be 0 while out_valid=1.
REQ-025 Outside EMIT_D and EMIT_C, out_valid SHALL be 0, selector 0, and data/count hold their last values.
REQ-026 out_ready asserted while out_valid=0 SHALL have no effect; in_valid while in_ready=0 SHALL have no effect and the word is not consumed.
REQ-027 Each beat SHALL complete in one cycle when out_ready is held high, giving a minimum of 2 cycles per emitted pair.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with the following values:
- data=0, count=0, selector=0, out_valid=0;
- run_cnt=0, pend_valid=0, pend_last=0;
- in_ready=1 once rst_n deasserts.
REQ-029 Reset asserted mid-run or mid-emit SHALL discard the open run and pending word immediately (asynchronously), with no partial pair emitted afterwards.

Verification
REQ-030 Bench SHALL cover: inputs A0A0A0A0 x3 then FFFFFFFF with in_last, out_ready=1 -> beats (A0A0A0A0,sel0),(cnt 3,sel1),(FFFFFFFF,sel0),(cnt 1,sel1), then IDLE.
REQ-031 Bench SHALL cover: 300 words of 00000000 with MAX_RUN=255, the last flagged -> pairs count=255 then count=45, no wrap.
REQ-032 Bench SHALL cover: out_ready=0 for 5 cycles during EMIT_D -> data/count/selector stable, in_ready=0, no input consumed; the pair completes after out_ready=1.
REQ-033 Bench SHALL cover: a single word 12345678 with in_last from IDLE -> (12345678,sel0),(count 1,sel1).
REQ-034 Bench SHALL cover: rst_n pulsed low during EMIT_C -> out_valid=0, count=0, data=0 immediately; the next input starts a fresh run at count 1.
REQ-035 Bench SHALL cover: a differing word arriving while in_valid held high -> the old pair is emitted first, the pending word is preserved, and no word is lost or duplicated (scoreboard compares decoded stream to input).
